// File: rtl/currency_accum_mc.sv
// Multi-channel coin accumulator: per-channel acceptance against a saturating running total,
// vend deduction and a greedy-change refund FSM with valid/ready handshake.
module currency_accum_mc #(
    parameter int CURRENCY_WIDTH = 7,
    parameter int NUM_CH         = 4,
    parameter int MAX_TOTAL      = 100,
    parameter int DENOM3         = 20,
    parameter int DENOM2         = 10,
    parameter int DENOM1         = 5
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_CH*CURRENCY_WIDTH-1:0] coin_value,
    input  logic [NUM_CH-1:0]                coin_valid,
    input  logic                             vend_req,
    input  logic [CURRENCY_WIDTH-1:0]        vend_price,
    input  logic                             refund_req,
    input  logic                             change_ready,
    output logic [CURRENCY_WIDTH-1:0]        total_currency,
    output logic                             currency_avail,
    output logic [NUM_CH-1:0]                coin_accept,
    output logic [NUM_CH-1:0]                coin_reject,
    output logic                             vend_ack,
    output logic                             vend_nack,
    output logic                             change_valid,
    output logic [CURRENCY_WIDTH-1:0]        change_value,
    output logic                             refund_done,
    output logic                             busy
);
    localparam int CW = CURRENCY_WIDTH;
    localparam int SW = CURRENCY_WIDTH + 4;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_REFUND = 1'b1;

    localparam logic [SW-1:0] MAX_S = SW'(MAX_TOTAL);
    localparam logic [CW-1:0] D3_C  = CW'(DENOM3);
    localparam logic [CW-1:0] D2_C  = CW'(DENOM2);
    localparam logic [CW-1:0] D1_C  = CW'(DENOM1);
    localparam logic [CW-1:0] ONE_C = CW'(1);

    logic [0:0]        r_state;
    logic [CW-1:0]     r_total;
    logic [NUM_CH-1:0] r_accept;
    logic [NUM_CH-1:0] r_reject;
    logic              r_ack;
    logic              r_nack;
    logic              r_done;

    logic              w_idle;
    logic              w_vend_ok;
    logic              w_vend_nack;
    logic [SW-1:0]     w_base;
    logic [SW-1:0]     w_sum [0:NUM_CH];
    logic [NUM_CH-1:0] w_acc;
    logic [NUM_CH-1:0] w_rej;
    logic [CW-1:0]     w_new_total;
    logic [CW-1:0]     w_change;
    logic [CW-1:0]     w_rem;
    logic              w_handshake;

    assign w_idle = (r_state == ST_IDLE);

    // Vend is funded only by the balance held at the start of the cycle; refund wins over vend.
    assign w_vend_ok   = vend_req && !refund_req && w_idle && (vend_price <= r_total);
    assign w_vend_nack = vend_req && !w_vend_ok;
    assign w_base      = w_vend_ok ? (SW'(r_total) - SW'(vend_price)) : SW'(r_total);
    assign w_sum[0]    = w_base;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [CW-1:0] w_val;
            logic [SW-1:0] w_cand;
            assign w_val         = coin_value[gi*CW +: CW];
            assign w_cand        = w_sum[gi] + SW'(w_val);
            assign w_acc[gi]     = w_idle && coin_valid[gi] && (w_val != '0) && (w_cand <= MAX_S);
            assign w_rej[gi]     = coin_valid[gi] && !w_acc[gi];
            assign w_sum[gi+1]   = w_acc[gi] ? w_cand : w_sum[gi];
        end
    endgenerate

    // The accepted sum never exceeds MAX_TOTAL, so the low CW bits hold it exactly.
    assign w_new_total = w_sum[NUM_CH][CW-1:0];

    always_comb begin
        w_change = '0;
        if (r_total >= D3_C)
            w_change = D3_C;
        else if (r_total >= D2_C)
            w_change = D2_C;
        else if (r_total >= D1_C)
            w_change = D1_C;
        else if (r_total != '0)
            w_change = ONE_C;
    end

    assign w_handshake = !w_idle && change_ready;
    assign w_rem       = r_total - w_change;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_total  <= '0;
            r_accept <= '0;
            r_reject <= '0;
            r_ack    <= 1'b0;
            r_nack   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_accept <= w_acc;
            r_reject <= w_rej;
            r_ack    <= w_vend_ok;
            r_nack   <= w_vend_nack;
            r_done   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_total <= w_new_total;
                    if (refund_req) begin
                        if (w_new_total != '0)
                            r_state <= ST_REFUND;
                        else
                            r_done <= 1'b1;
                    end
                end
                default: begin
                    if (w_handshake) begin
                        r_total <= w_rem;
                        if (w_rem == '0) begin
                            r_state <= ST_IDLE;
                            r_done  <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign total_currency = r_total;
    assign currency_avail = (r_total != '0);
    assign coin_accept    = r_accept;
    assign coin_reject    = r_reject;
    assign vend_ack       = r_ack;
    assign vend_nack      = r_nack;
    assign change_valid   = !w_idle;
    assign change_value   = w_idle ? '0 : w_change;
    assign refund_done    = r_done;
    assign busy           = !w_idle;

endmodule

// File: tb/tb_currency_accum_mc.sv
// Scoreboard bench for currency_accum_mc: directed coin/vend/refund vectors push expected
// responses; a negedge monitor pops and compares whenever the DUT presents a pulse or change coin.
module tb_currency_accum_mc;
    logic        clk = 1'b0;
    logic        rst;
    logic [27:0] coin_value;
    logic [3:0]  coin_valid;
    logic        vend_req;
    logic [6:0]  vend_price;
    logic        refund_req;
    logic        change_ready;
    logic [6:0]  total_currency;
    logic        currency_avail;
    logic [3:0]  coin_accept;
    logic [3:0]  coin_reject;
    logic        vend_ack;
    logic        vend_nack;
    logic        change_valid;
    logic [6:0]  change_value;
    logic        refund_done;
    logic        busy;

    currency_accum_mc dut (
        .clk            (clk),
        .rst            (rst),
        .coin_value     (coin_value),
        .coin_valid     (coin_valid),
        .vend_req       (vend_req),
        .vend_price     (vend_price),
        .refund_req     (refund_req),
        .change_ready   (change_ready),
        .total_currency (total_currency),
        .currency_avail (currency_avail),
        .coin_accept    (coin_accept),
        .coin_reject    (coin_reject),
        .vend_ack       (vend_ack),
        .vend_nack      (vend_nack),
        .change_valid   (change_valid),
        .change_value   (change_value),
        .refund_done    (refund_done),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] acc;
        logic [3:0] rej;
        logic       ack;
        logic       nack;
        logic       done;
        logic       bsy;
        logic [6:0] total;
    } pulse_t;

    typedef struct {
        logic [6:0] value;
        logic [6:0] total;
    } chg_t;

    pulse_t q_pulse[$];
    chg_t   q_chg[$];
    pulse_t p;
    chg_t   c;
    int     n_vec  = 0;
    int     n_fail = 0;
    logic   mon_en = 1'b0;

    // Monitor: compares every presented pulse and every offered change coin against the queues.
    always @(negedge clk) begin
        if (mon_en) begin
            if ((|coin_accept) || (|coin_reject) || vend_ack || vend_nack || refund_done) begin
                n_vec++;
                if (q_pulse.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_pulse: acc=%b rej=%b ack=%b nack=%b done=%b total=%0d, none required",
                             coin_accept, coin_reject, vend_ack, vend_nack, refund_done, total_currency);
                end else begin
                    p = q_pulse.pop_front();
                    if ({coin_accept, coin_reject, vend_ack, vend_nack, refund_done, busy, total_currency} !==
                        {p.acc, p.rej, p.ack, p.nack, p.done, p.bsy, p.total}) begin
                        n_fail++;
                        $display("FAIL pulse: got acc=%b rej=%b ack=%b nack=%b done=%b busy=%b total=%0d, required acc=%b rej=%b ack=%b nack=%b done=%b busy=%b total=%0d",
                                 coin_accept, coin_reject, vend_ack, vend_nack, refund_done, busy, total_currency,
                                 p.acc, p.rej, p.ack, p.nack, p.done, p.bsy, p.total);
                    end else
                        $display("pulse  acc=%b rej=%b ack=%b nack=%b done=%b total=%0d ok",
                                 coin_accept, coin_reject, vend_ack, vend_nack, refund_done, total_currency);
                end
            end
            if (change_valid) begin
                n_vec++;
                if (q_chg.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_change: value=%0d total=%0d, none required", change_value, total_currency);
                end else begin
                    c = q_chg[0];
                    if ({change_value, total_currency, busy} !== {c.value, c.total, 1'b1}) begin
                        n_fail++;
                        $display("FAIL change: got value=%0d total=%0d busy=%b, required value=%0d total=%0d busy=1",
                                 change_value, total_currency, busy, c.value, c.total);
                    end else if (change_ready)
                        $display("change value=%0d total=%0d ok", change_value, total_currency);
                    if (change_ready)
                        void'(q_chg.pop_front());
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end else
            $display("check %s = %0d ok", name, act);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] v, input logic [6:0] c0, input logic [6:0] c1,
                         input logic [6:0] c2, input logic [6:0] c3,
                         input logic vr, input logic [6:0] pr, input logic rr);
        coin_valid = v;
        coin_value = {c3, c2, c1, c0};
        vend_req   = vr;
        vend_price = pr;
        refund_req = rr;
        tick();
        coin_valid = '0;
        coin_value = '0;
        vend_req   = 1'b0;
        vend_price = '0;
        refund_req = 1'b0;
    endtask

    task automatic exp_p(input logic [3:0] acc, input logic [3:0] rej, input logic ack, input logic nack,
                         input logic done, input logic bsy, input logic [6:0] total);
        pulse_t e;
        e.acc = acc; e.rej = rej; e.ack = ack; e.nack = nack; e.done = done; e.bsy = bsy; e.total = total;
        q_pulse.push_back(e);
    endtask

    task automatic exp_c(input logic [6:0] value, input logic [6:0] total);
        chg_t e;
        e.value = value; e.total = total;
        q_chg.push_back(e);
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_total"}, 32'(total_currency), 0);
        chk({tag, "_avail"}, 32'(currency_avail), 0);
        chk({tag, "_busy"},  32'(busy), 0);
        chk({tag, "_cvalid"}, 32'(change_valid), 0);
        chk({tag, "_cvalue"}, 32'(change_value), 0);
        chk({tag, "_pulses"}, 32'({coin_accept, coin_reject, vend_ack, vend_nack, refund_done}), 0);
    endtask

    initial begin
        rst = 1'b1;
        coin_value = '0; coin_valid = '0; vend_req = 1'b0; vend_price = '0;
        refund_req = 1'b0; change_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk_idle_zero("reset");
        mon_en = 1'b1;

        // Two channels accepted in one cycle
        exp_p(4'b0101, 4'b0000, 0, 0, 0, 0, 7'd15);
        drive(4'b0101, 7'd5, 7'd0, 7'd10, 7'd0, 0, 7'd0, 0);
        chk("avail_15", 32'(currency_avail), 1);
        exp_p(4'b1111, 4'b0000, 0, 0, 0, 0, 7'd95);
        drive(4'b1111, 7'd20, 7'd20, 7'd20, 7'd20, 0, 7'd0, 0);
        // Saturation: ch0 fits, ch1 would overflow
        exp_p(4'b0001, 4'b0010, 0, 0, 0, 0, 7'd98);
        drive(4'b0011, 7'd3, 7'd5, 7'd0, 7'd0, 0, 7'd0, 0);
        // Zero-valued coin rejected; exact fill to MAX_TOTAL accepted
        exp_p(4'b1000, 4'b0100, 0, 0, 0, 0, 7'd100);
        drive(4'b1100, 7'd0, 7'd0, 7'd0, 7'd2, 0, 7'd0, 0);
        exp_p(4'b0000, 4'b0001, 0, 0, 0, 0, 7'd100);
        drive(4'b0001, 7'd1, 7'd0, 7'd0, 7'd0, 0, 7'd0, 0);
        // Vends
        exp_p(4'b0000, 4'b0000, 1, 0, 0, 0, 7'd30);
        drive(4'b0000, 7'd0, 7'd0, 7'd0, 7'd0, 1, 7'd70, 0);
        exp_p(4'b0010, 4'b0000, 1, 0, 0, 0, 7'd15);
        drive(4'b0010, 7'd0, 7'd10, 7'd0, 7'd0, 1, 7'd25, 0);
        exp_p(4'b0000, 4'b0000, 0, 1, 0, 0, 7'd15);
        drive(4'b0000, 7'd0, 7'd0, 7'd0, 7'd0, 1, 7'd20, 0);
        exp_p(4'b0000, 4'b0000, 1, 0, 0, 0, 7'd15);
        drive(4'b0000, 7'd0, 7'd0, 7'd0, 7'd0, 1, 7'd0, 0);
        // Price equal to balance; coin checked against post-deduction sum
        exp_p(4'b0001, 4'b0000, 1, 0, 0, 0, 7'd90);
        drive(4'b0001, 7'd90, 7'd0, 7'd0, 7'd0, 1, 7'd15, 0);
        exp_p(4'b0000, 4'b0000, 1, 0, 0, 0, 7'd30);
        drive(4'b0000, 7'd0, 7'd0, 7'd0, 7'd0, 1, 7'd60, 0);

        // Refund of 38 (30 + same-cycle coin 8), vend in same cycle refused
        exp_c(7'd20, 7'd38); exp_c(7'd10, 7'd18); exp_c(7'd5, 7'd8);
        exp_c(7'd1, 7'd3);   exp_c(7'd1, 7'd2);   exp_c(7'd1, 7'd1);
        exp_p(4'b0010, 4'b0000, 0, 1, 0, 1, 7'd38);
        drive(4'b0010, 7'd0, 7'd8, 7'd0, 7'd0, 1, 7'd1, 1);
        exp_p(4'b0000, 4'b0100, 0, 1, 0, 1, 7'd38);
        exp_p(4'b0000, 4'b0000, 0, 0, 1, 0, 7'd0);
        drive(4'b0100, 7'd0, 7'd0, 7'd5, 7'd0, 1, 7'd3, 1);
        for (int k = 0; k < 6; k++) begin
            tick();
            change_ready = 1'b1;
            tick();
            change_ready = 1'b0;
        end
        tick();
        chk("post_refund_busy", 32'(busy), 0);
        chk("post_refund_total", 32'(total_currency), 0);

        // Refund at zero balance: no REFUND entry
        exp_p(4'b0000, 4'b0000, 0, 1, 1, 0, 7'd0);
        drive(4'b0000, 7'd0, 7'd0, 7'd0, 7'd0, 1, 7'd5, 1);
        tick();
        chk("zero_refund_busy", 32'(busy), 0);
        chk("zero_refund_cvalid", 32'(change_valid), 0);

        // Reset in the middle of a refund
        exp_p(4'b0111, 4'b0000, 0, 0, 0, 0, 7'd50);
        drive(4'b0111, 7'd20, 7'd20, 7'd10, 7'd0, 0, 7'd0, 0);
        exp_c(7'd20, 7'd50);
        drive(4'b0000, 7'd0, 7'd0, 7'd0, 7'd0, 0, 7'd0, 1);
        chk("refund_entered", 32'(busy), 1);
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        q_chg.delete();
        chk_idle_zero("midreset");
        tick(); tick();

        chk("pulse_queue_drained", 32'(q_pulse.size()), 0);
        chk("change_queue_drained", 32'(q_chg.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded bound");
        $fatal(1);
    end
endmodule
